pdp8_mem_arbiter: RTL and testbench

Single-port memory arbiter for the PDP-8 core. It shares the one memory port between the instruction fetch/decode unit's read requests and the execution unit's read and write requests. Each requester's single-cycle request pulse is captured in a one-entry holding slot, and at most one memory operation is issued per cycle under fixed priority. Read data is routed back to the originating requester with a one-cycle valid strobe. The block sits between the IFD/EXEC units and the memory model.

---
 rtl/pdp8_pkg.sv | 20 ++
 rtl/pdp8_req_slot.sv | 51 +++++
 rtl/pdp8_mem_arbiter.sv | 159 +++++++++++++++
 tb/tb_pdp8_mem_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pdp8_pkg.sv
// Shared PDP-8 core definitions: memory geometry and the read return source tag.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 12
`endif

package pdp8_pkg;

  // Originator of a memory read; SRC_NONE means no read is in flight.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_IFU  = 2'd1,
    SRC_EXEC = 2'd2
  } mem_src_e;

  localparam int unsigned NUM_REQ_SLOTS = 3;

endpackage

// File: rtl/pdp8_req_slot.sv
// One-entry request holding slot. A pending entry is offered as a grant
// candidate ahead of a same-cycle pulse; an un-pending pulse is offered
// directly so an idle requester sees no extra latency.
module pdp8_req_slot #(
  parameter int unsigned WIDTH = 12
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req,
  input  logic [WIDTH-1:0] req_payload,
  input  logic             grant,
  output logic             cand_valid,
  output logic [WIDTH-1:0] cand_payload,
  output logic             valid_next,
  output logic             overflow
);

  logic             valid_r;
  logic [WIDTH-1:0] payload_r;

  // Candidate presented to the arbiter, next occupancy and drop detection.
  always_comb begin
    cand_valid   = valid_r | req;
    cand_payload = valid_r ? payload_r : req_payload;
    overflow     = req & valid_r & ~grant;
    if (grant) begin
      // Granted entry leaves; a pulse behind a stored entry refills the slot.
      valid_next = valid_r & req;
    end else begin
      valid_next = valid_r | req;
    end
  end

  // Slot storage: fill on an empty-slot pulse or a same-cycle refill, clear on grant.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_r   <= 1'b0;
      payload_r <= '0;
    end else begin
      valid_r <= valid_next;
      if (req && (!valid_r || grant) && !(grant && !valid_r)) begin
        payload_r <= req_payload;
      end else if (req && !valid_r && !grant) begin
        payload_r <= req_payload;
      end else begin
        payload_r <= payload_r;
      end
    end
  end

endmodule

// File: rtl/pdp8_mem_arbiter.sv
// Single-port memory arbiter: fixed priority EXEC_WR > EXEC_RD > IFU_RD,
// registered memory commands and a two-stage tag pipeline that steers the
// returning read word back to its requester.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 12
`endif

module pdp8_mem_arbiter
  import pdp8_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = `ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = `DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ifu_rd_req,
  input  logic [ADDR_WIDTH-1:0] ifu_rd_addr,
  output logic [DATA_WIDTH-1:0] ifu_rd_data,
  output logic                  ifu_rd_valid,
  input  logic                  exec_rd_req,
  input  logic [ADDR_WIDTH-1:0] exec_rd_addr,
  output logic [DATA_WIDTH-1:0] exec_rd_data,
  output logic                  exec_rd_valid,
  input  logic                  exec_wr_req,
  input  logic [ADDR_WIDTH-1:0] exec_wr_addr,
  input  logic [DATA_WIDTH-1:0] exec_wr_data,
  output logic                  mem_rd_req,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  mem_wr_req,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic                  busy,
  output logic                  req_overflow
);

  localparam int unsigned WR_WIDTH = ADDR_WIDTH + DATA_WIDTH;

  logic                  ifu_cand_s, erd_cand_s, ewr_cand_s;
  logic [ADDR_WIDTH-1:0] ifu_addr_s, erd_addr_s;
  logic [WR_WIDTH-1:0]   ewr_payload_s;
  logic                  ifu_vnext_s, erd_vnext_s, ewr_vnext_s;
  logic                  ifu_ovf_s, erd_ovf_s, ewr_ovf_s;
  logic                  grant_ifu_s, grant_erd_s, grant_ewr_s;

  logic                  rd_req_s, wr_req_s, busy_s, overflow_s;
  logic [ADDR_WIDTH-1:0] rd_addr_s, wr_addr_s;
  logic [DATA_WIDTH-1:0] wr_data_s;
  mem_src_e              issue_tag_s;

  mem_src_e              issue_tag_r;
  mem_src_e              ret_tag_r;

  pdp8_req_slot #(.WIDTH(ADDR_WIDTH)) u_ifu_slot (
    .clk(clk), .reset_n(reset_n), .req(ifu_rd_req), .req_payload(ifu_rd_addr),
    .grant(grant_ifu_s), .cand_valid(ifu_cand_s), .cand_payload(ifu_addr_s),
    .valid_next(ifu_vnext_s), .overflow(ifu_ovf_s)
  );

  pdp8_req_slot #(.WIDTH(ADDR_WIDTH)) u_erd_slot (
    .clk(clk), .reset_n(reset_n), .req(exec_rd_req), .req_payload(exec_rd_addr),
    .grant(grant_erd_s), .cand_valid(erd_cand_s), .cand_payload(erd_addr_s),
    .valid_next(erd_vnext_s), .overflow(erd_ovf_s)
  );

  pdp8_req_slot #(.WIDTH(WR_WIDTH)) u_ewr_slot (
    .clk(clk), .reset_n(reset_n), .req(exec_wr_req),
    .req_payload({exec_wr_addr, exec_wr_data}),
    .grant(grant_ewr_s), .cand_valid(ewr_cand_s), .cand_payload(ewr_payload_s),
    .valid_next(ewr_vnext_s), .overflow(ewr_ovf_s)
  );

  // Fixed-priority grant: at most one candidate wins each cycle.
  always_comb begin
    grant_ewr_s = ewr_cand_s;
    grant_erd_s = erd_cand_s & ~ewr_cand_s;
    grant_ifu_s = ifu_cand_s & ~ewr_cand_s & ~erd_cand_s;
  end

  // Next values of the memory command, tag and status registers.
  always_comb begin
    rd_req_s    = 1'b0;
    rd_addr_s   = '0;
    wr_req_s    = 1'b0;
    wr_addr_s   = '0;
    wr_data_s   = '0;
    issue_tag_s = SRC_NONE;
    if (grant_ewr_s) begin
      wr_req_s  = 1'b1;
      wr_addr_s = ewr_payload_s[WR_WIDTH-1:DATA_WIDTH];
      wr_data_s = ewr_payload_s[DATA_WIDTH-1:0];
    end else if (grant_erd_s) begin
      rd_req_s    = 1'b1;
      rd_addr_s   = erd_addr_s;
      issue_tag_s = SRC_EXEC;
    end else if (grant_ifu_s) begin
      rd_req_s    = 1'b1;
      rd_addr_s   = ifu_addr_s;
      issue_tag_s = SRC_IFU;
    end else begin
      rd_req_s = 1'b0;
    end
    // Busy covers pending slots, the command being issued and the read returning next.
    busy_s     = ifu_vnext_s | erd_vnext_s | ewr_vnext_s | rd_req_s | wr_req_s |
                 (issue_tag_r != SRC_NONE);
    overflow_s = ifu_ovf_s | erd_ovf_s | ewr_ovf_s;
  end

  // Registered memory commands, status and the return-tag pipeline.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mem_rd_req   <= 1'b0;
      mem_rd_addr  <= '0;
      mem_wr_req   <= 1'b0;
      mem_wr_addr  <= '0;
      mem_wr_data  <= '0;
      busy         <= 1'b0;
      req_overflow <= 1'b0;
      issue_tag_r  <= SRC_NONE;
      ret_tag_r    <= SRC_NONE;
    end else begin
      mem_rd_req   <= rd_req_s;
      mem_rd_addr  <= rd_addr_s;
      mem_wr_req   <= wr_req_s;
      mem_wr_addr  <= wr_addr_s;
      mem_wr_data  <= wr_data_s;
      busy         <= busy_s;
      req_overflow <= overflow_s;
      issue_tag_r  <= issue_tag_s;
      ret_tag_r    <= issue_tag_r;
    end
  end

  // Steer the returning memory word to the tagged requester; others see 0.
  always_comb begin
    ifu_rd_valid  = 1'b0;
    ifu_rd_data   = '0;
    exec_rd_valid = 1'b0;
    exec_rd_data  = '0;
    case (ret_tag_r)
      SRC_IFU: begin
        ifu_rd_valid = 1'b1;
        ifu_rd_data  = mem_rd_data;
      end
      SRC_EXEC: begin
        exec_rd_valid = 1'b1;
        exec_rd_data  = mem_rd_data;
      end
      default: begin
        ifu_rd_valid  = 1'b0;
        exec_rd_valid = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_pdp8_mem_arbiter.sv
// Self-checking bench for pdp8_mem_arbiter with a one-cycle-latency memory model.
module tb_pdp8_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ifu_rd_req, exec_rd_req, exec_wr_req;
  logic [11:0] ifu_rd_addr, exec_rd_addr, exec_wr_addr, exec_wr_data;
  logic [11:0] ifu_rd_data, exec_rd_data;
  logic        ifu_rd_valid, exec_rd_valid;
  logic        mem_rd_req, mem_wr_req;
  logic [11:0] mem_rd_addr, mem_wr_addr, mem_wr_data;
  logic [11:0] mem_rd_data;
  logic        busy, req_overflow;

  logic        mem_init = 1'b0;
  logic        pre_en = 1'b0;
  logic [11:0] pre_addr = 12'd0;
  logic [11:0] pre_data = 12'd0;
  logic [11:0] mem [0:4095];
  logic [11:0] ref_mem [0:4095];

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          due;
    bit          is_ifu;
    logic [11:0] data;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  pdp8_mem_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .ifu_rd_req(ifu_rd_req), .ifu_rd_addr(ifu_rd_addr),
    .ifu_rd_data(ifu_rd_data), .ifu_rd_valid(ifu_rd_valid),
    .exec_rd_req(exec_rd_req), .exec_rd_addr(exec_rd_addr),
    .exec_rd_data(exec_rd_data), .exec_rd_valid(exec_rd_valid),
    .exec_wr_req(exec_wr_req), .exec_wr_addr(exec_wr_addr), .exec_wr_data(exec_wr_data),
    .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .mem_wr_req(mem_wr_req), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .busy(busy), .req_overflow(req_overflow)
  );

  function automatic logic [11:0] init_word(int i);
    return 12'((i * 37) + 5);
  endfunction

  // Memory model: write on command, read data one cycle after the read command.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 4096; i++) mem[i] <= init_word(i);
    end else begin
      if (pre_en) mem[pre_addr] <= pre_data;
      if (mem_wr_req) mem[mem_wr_addr] <= mem_wr_data;
    end
    if (mem_rd_req) mem_rd_data <= mem[mem_rd_addr];
    else mem_rd_data <= 12'($urandom);
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ifu_rd_req  = 1'b0;
    exec_rd_req = 1'b0;
    exec_wr_req = 1'b0;
  endtask

  task automatic preload(input logic [11:0] a, input logic [11:0] d);
    next_cycle();
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    next_cycle();
    pre_en = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle();
    ifu_rd_addr = 12'd0; exec_rd_addr = 12'd0; exec_wr_addr = 12'd0; exec_wr_data = 12'd0;
    mem_init = 1'b1;
    for (int i = 0; i < 4096; i++) ref_mem[i] = init_word(i);
    next_cycle();
    next_cycle();
    mem_init = 1'b0;
    @(negedge clk);
    checks++;
    if ({mem_rd_req, mem_wr_req, busy, req_overflow, ifu_rd_valid, exec_rd_valid} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 000000",
               {mem_rd_req, mem_wr_req, busy, req_overflow, ifu_rd_valid, exec_rd_valid});
    end
    checks++;
    if ({mem_rd_addr, mem_wr_addr, mem_wr_data, ifu_rd_data, exec_rd_data} !== 60'd0) begin
      errors++;
      $display("FAIL reset_data: got %h expected 0",
               {mem_rd_addr, mem_wr_addr, mem_wr_data, ifu_rd_data, exec_rd_data});
    end
    next_cycle();
    reset_n = 1'b1;
  endtask

  task automatic test_single_read();
    preload(12'o200, 12'o7001);
    next_cycle();
    ifu_rd_req = 1'b1; ifu_rd_addr = 12'o200;
    next_cycle();
    idle();
    @(negedge clk);
    checks++;
    if (mem_rd_req !== 1'b1 || mem_rd_addr !== 12'o200 || mem_wr_req !== 1'b0) begin
      errors++;
      $display("FAIL single_issue: got rd=%b addr=%o wr=%b expected rd=1 addr=200 wr=0",
               mem_rd_req, mem_rd_addr, mem_wr_req);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (ifu_rd_valid !== 1'b1 || ifu_rd_data !== 12'o7001 || exec_rd_valid !== 1'b0 ||
        exec_rd_data !== 12'd0) begin
      errors++;
      $display("FAIL single_return: got v=%b d=%o ev=%b ed=%o expected v=1 d=7001 ev=0 ed=0",
               ifu_rd_valid, ifu_rd_data, exec_rd_valid, exec_rd_data);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (ifu_rd_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_after: got v=%b busy=%b expected 0 0", ifu_rd_valid, busy);
    end
  endtask

  task automatic test_write_then_read();
    next_cycle();
    exec_wr_req = 1'b1; exec_wr_addr = 12'o300; exec_wr_data = 12'o1234;
    ifu_rd_req  = 1'b1; ifu_rd_addr  = 12'o300;
    ref_mem[12'o300] = 12'o1234;
    next_cycle();
    idle();
    @(negedge clk);
    checks++;
    if (mem_wr_req !== 1'b1 || mem_wr_addr !== 12'o300 || mem_wr_data !== 12'o1234 ||
        mem_rd_req !== 1'b0) begin
      errors++;
      $display("FAIL wr_issue: got wr=%b a=%o d=%o rd=%b expected 1 300 1234 0",
               mem_wr_req, mem_wr_addr, mem_wr_data, mem_rd_req);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (mem_rd_req !== 1'b1 || mem_rd_addr !== 12'o300 || mem_wr_req !== 1'b0) begin
      errors++;
      $display("FAIL wr_rd_issue: got rd=%b a=%o wr=%b expected 1 300 0",
               mem_rd_req, mem_rd_addr, mem_wr_req);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (ifu_rd_valid !== 1'b1 || ifu_rd_data !== ref_mem[12'o300]) begin
      errors++;
      $display("FAIL wr_rd_return: got v=%b d=%o expected v=1 d=%o",
               ifu_rd_valid, ifu_rd_data, ref_mem[12'o300]);
    end
  endtask

  task automatic test_all_three();
    logic [11:0] a, b, c, d;
    a = 12'($urandom); b = 12'($urandom); c = 12'($urandom); d = 12'($urandom);
    next_cycle();
    exec_wr_req = 1'b1; exec_wr_addr = a; exec_wr_data = d;
    exec_rd_req = 1'b1; exec_rd_addr = b;
    ifu_rd_req  = 1'b1; ifu_rd_addr  = c;
    ref_mem[a] = d;
    next_cycle();
    idle();
    @(negedge clk);
    checks++;
    if (mem_wr_req !== 1'b1 || mem_wr_addr !== a || mem_rd_req !== 1'b0) begin
      errors++;
      $display("FAIL all3_wr: got wr=%b a=%h rd=%b expected 1 %h 0", mem_wr_req, mem_wr_addr, mem_rd_req, a);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (mem_rd_req !== 1'b1 || mem_rd_addr !== b || mem_wr_req !== 1'b0) begin
      errors++;
      $display("FAIL all3_erd: got rd=%b a=%h wr=%b expected 1 %h 0", mem_rd_req, mem_rd_addr, mem_wr_req, b);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (mem_rd_req !== 1'b1 || mem_rd_addr !== c || exec_rd_valid !== 1'b1 ||
        exec_rd_data !== ref_mem[b] || ifu_rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL all3_n3: got rd=%b a=%h ev=%b ed=%h iv=%b expected 1 %h 1 %h 0",
               mem_rd_req, mem_rd_addr, exec_rd_valid, exec_rd_data, ifu_rd_valid, c, ref_mem[b]);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (ifu_rd_valid !== 1'b1 || ifu_rd_data !== ref_mem[c] || exec_rd_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL all3_n4: got iv=%b id=%h ev=%b busy=%b expected 1 %h 0 1",
               ifu_rd_valid, ifu_rd_data, exec_rd_valid, busy, ref_mem[c]);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || ifu_rd_valid !== 1'b0 || exec_rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL all3_n5: got busy=%b iv=%b ev=%b expected 0 0 0", busy, ifu_rd_valid, exec_rd_valid);
    end
  endtask

  task automatic test_overflow();
    logic [11:0] wa, eb, fa, fb;
    wa = 12'($urandom); eb = 12'($urandom); fa = 12'($urandom); fb = fa ^ 12'd1;
    next_cycle();
    exec_wr_req = 1'b1; exec_wr_addr = wa; exec_wr_data = 12'($urandom);
    exec_rd_req = 1'b1; exec_rd_addr = eb;
    ifu_rd_req  = 1'b1; ifu_rd_addr  = fa;
    ref_mem[wa] = exec_wr_data;
    next_cycle();
    idle();
    ifu_rd_req = 1'b1; ifu_rd_addr = fb;
    @(negedge clk);
    checks++;
    if (req_overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_early: got %b expected 0", req_overflow);
    end
    next_cycle();
    idle();
    @(negedge clk);
    checks++;
    if (req_overflow !== 1'b1 || mem_rd_req !== 1'b1 || mem_rd_addr !== eb) begin
      errors++;
      $display("FAIL ovf_pulse: got ovf=%b rd=%b a=%h expected 1 1 %h", req_overflow, mem_rd_req, mem_rd_addr, eb);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (req_overflow !== 1'b0 || mem_rd_req !== 1'b1 || mem_rd_addr !== fa) begin
      errors++;
      $display("FAIL ovf_kept: got ovf=%b rd=%b a=%h expected 0 1 %h", req_overflow, mem_rd_req, mem_rd_addr, fa);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (ifu_rd_valid !== 1'b1 || ifu_rd_data !== ref_mem[fa] || mem_rd_req !== 1'b0) begin
      errors++;
      $display("FAIL ovf_return: got v=%b d=%h rd=%b expected 1 %h 0", ifu_rd_valid, ifu_rd_data, mem_rd_req, ref_mem[fa]);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (ifu_rd_valid !== 1'b0 || mem_rd_req !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ovf_dropped: got v=%b rd=%b busy=%b expected 0 0 0", ifu_rd_valid, mem_rd_req, busy);
    end
  endtask

  task automatic test_reset_midflight();
    next_cycle();
    ifu_rd_req = 1'b1; ifu_rd_addr = 12'($urandom);
    next_cycle();
    idle();
    reset_n = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_rd_req !== 1'b1) begin
      errors++;
      $display("FAIL midrst_pre: got rd=%b expected 1", mem_rd_req);
    end
    next_cycle();
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({mem_rd_req, mem_wr_req, busy, req_overflow, ifu_rd_valid, exec_rd_valid} !== 6'b0 ||
        {mem_rd_addr, ifu_rd_data, exec_rd_data} !== 36'd0) begin
      errors++;
      $display("FAIL midrst_zero: got ctl=%b data=%h expected 0",
               {mem_rd_req, mem_wr_req, busy, req_overflow, ifu_rd_valid, exec_rd_valid},
               {mem_rd_addr, ifu_rd_data, exec_rd_data});
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (ifu_rd_valid !== 1'b0 || exec_rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_after: got iv=%b ev=%b expected 0 0", ifu_rd_valid, exec_rd_valid);
    end
  endtask

  task automatic test_back_to_back();
    int   n_valid;
    exp_t e;
    n_valid = 0;
    exp_q.delete();
    for (int k = 0; k < 104; k++) begin
      next_cycle();
      idle();
      if (k < 100) begin
        logic [11:0] a;
        a = 12'($urandom);
        e.due = k + 2;
        e.is_ifu = (k % 2) == 0;
        e.data = ref_mem[a];
        exp_q.push_back(e);
        if (e.is_ifu) begin
          ifu_rd_req = 1'b1; ifu_rd_addr = a;
        end else begin
          exec_rd_req = 1'b1; exec_rd_addr = a;
        end
      end
      @(negedge clk);
      if (ifu_rd_valid === 1'b1 || exec_rd_valid === 1'b1) n_valid++;
      if (exp_q.size() > 0 && exp_q[0].due == k) begin
        e = exp_q.pop_front();
        checks++;
        if (ifu_rd_valid !== e.is_ifu || exec_rd_valid !== !e.is_ifu ||
            (e.is_ifu ? ifu_rd_data : exec_rd_data) !== e.data) begin
          errors++;
          $display("FAIL b2b_ret k=%0d: got iv=%b id=%h ev=%b ed=%h expected ifu=%b data=%h",
                   k, ifu_rd_valid, ifu_rd_data, exec_rd_valid, exec_rd_data, e.is_ifu, e.data);
        end
      end else begin
        checks++;
        if (ifu_rd_valid !== 1'b0 || exec_rd_valid !== 1'b0) begin
          errors++;
          $display("FAIL b2b_idle k=%0d: got iv=%b ev=%b expected 0 0", k, ifu_rd_valid, exec_rd_valid);
        end
      end
      checks++;
      if (req_overflow !== 1'b0) begin
        errors++;
        $display("FAIL b2b_ovf k=%0d: got %b expected 0", k, req_overflow);
      end
    end
    checks++;
    if (n_valid != 100 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_count: got valids=%0d left=%0d expected 100 0", n_valid, exp_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_read();
    test_write_then_read();
    test_all_three();
    test_overflow();
    test_reset_midflight();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
